dmem_req_ctrl: RTL and testbench
================================

Name: dmem_req_ctrl

Overview:
- M-stage data-memory access controller. It turns the pipeline's load/store request into an SRAM-like bus transaction (req/addr_ok/data_ok).
- It generates the `d_stall` consumed by the hazard unit and returns load data to the M/W path.
- It is the producer end of the `d_stall` handshake. It holds returned data while other stall sources keep the pipeline frozen.

Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_enM  in  1  M-stage instruction is a load/store
- mem_wenM  in  1  1=store, 0=load
- mem_sizeM  in  2  0=byte, 1=half, 2=word (3 illegal, treated as word)
- mem_addrM  in  AW  byte address
- mem_wdataM  in  DW  store data, already lane-aligned
- except_flushM  in  1  M-stage exception pending (except_typeM!=0)
- other_stall  in  1  OR of non-data stall sources (i_stall, stall_divE, div_stall_extend, gap_stall)
- d_stall  out  1  data-side stall to hazard unit
- mem_rdataM  out  DW  load result for M stage
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size
- data_addr  out  AW  bus address
- data_wdata  out  DW  bus write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  data returned / write done
- data_rdata  in  DW  bus read data

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- States: IDLE, ADDR, DATA, HOLD.
- Reset:
  - state=IDLE, kill_q=0, rdata_q=0, payload regs=0.
  - Outputs: d_stall=0, data_req=0, mem_rdataM=0.
  - Reset mid-transaction abandons it; the bus slave is reset on the same `rst`.
- start = (state==IDLE) & mem_enM & !except_flushM.
- IDLE:
  - data_req=start; bus fields driven directly from the M inputs; payload latched into regs when start.
  - start & addr_ok -> DATA; start & !addr_ok -> ADDR.
  - except_flushM blocks issue entirely (e.g. an address-error load never reaches the bus).
- ADDR:
  - data_req=1; bus fields come from the latched payload and stay stable until accepted; the request is never withdrawn.
  - addr_ok -> DATA.
- DATA:
  - data_req=0; wait for data_ok. data_ok never arrives in the same cycle as its own addr_ok.
  - On data_ok: rdata_q<=data_rdata.
  - Next state: kill_q -> IDLE; else other_stall -> HOLD; else IDLE.
- HOLD:
  - No bus activity; d_stall=0; mem_rdataM=rdata_q.
  - !other_stall -> IDLE (the pipeline advances on this edge).
- d_stall = start | (state==ADDR) | (state==DATA & !data_ok) | (state==DATA & kill_q).
- mem_rdataM = (state==DATA) ? data_rdata : rdata_q. Zero-latency forward in the data_ok cycle.
- Kill:
  - except_flushM asserted in ADDR/DATA sets kill_q.
  - The transaction still completes and d_stall stays high until data_ok; the result is discarded (rdata_q not updated); state returns to IDLE; kill_q clears on leaving DATA.
- Stores follow the same path; mem_rdataM is don't-care for stores. In HOLD after a store, rdata_q holds its previous value.
- One outstanding transaction max. No new request is issued from ADDR/DATA/HOLD.
- Latency:
  - Minimum load = 2 cycles (issue + data_ok next cycle), d_stall high 1 cycle.
  - Each addr_ok / data_ok wait cycle adds one stall cycle.

Test Plan:
- Load word, addr 0x8000_0010: addr_ok in the issue cycle, data_ok next cycle with 0xDEADBEEF -> d_stall high 1 cycle; mem_rdataM=0xDEADBEEF in the data_ok cycle; back to IDLE.
- Store byte, addr 0x8000_0003, wdata 0x0000_00AB: addr_ok delayed 3 cycles -> data_req held 4 cycles with size=0, wr=1, addr/wdata stable; d_stall high until data_ok.
- Load returns 0x12345678 while other_stall=1 for 3 more cycles -> HOLD; d_stall=0; mem_rdataM stays 0x12345678; data_req=0 throughout; IDLE when other_stall drops.
- except_flushM=1 with mem_enM=1 in IDLE -> data_req=0, d_stall=0.
- except_flushM pulses in DATA, data_ok 2 cycles later with 0x55AA55AA -> d_stall high until data_ok; rdata_q unchanged; next state IDLE.
- rst asserted while in ADDR -> next cycle state IDLE, data_req=0, d_stall=0, mem_rdataM=0.

Source files
------------

// File: rtl/dmem_req_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_req_ctrl_if
// SRAM-like data bus between the M-stage memory controller (master) and the
// data memory / bus bridge (slave).
//
// Signals:
//   data_req      master->slave  request valid, held until data_addr_ok
//   data_wr       master->slave  1 = write, 0 = read
//   data_size     master->slave  0 = byte, 1 = half, 2 = word
//   data_addr     master->slave  byte address
//   data_wdata    master->slave  lane-aligned write data
//   data_addr_ok  slave->master  request accepted this cycle
//   data_data_ok  slave->master  read data valid / write complete
//   data_rdata    slave->master  read data
// -----------------------------------------------------------------------------
interface dmem_req_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/dmem_req_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_req_ctrl
// M-stage data-memory access controller. Converts the pipeline's load/store
// into a single outstanding SRAM-like bus transaction, raises d_stall while the
// pipeline must wait for it, and returns load data on mem_rdataM. If another
// stall source keeps the pipeline frozen when data returns, the load result is
// held in rdata_reg until the pipeline advances.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_enM         M-stage instruction is a load/store
//   mem_wenM        1 = store, 0 = load
//   mem_sizeM       0 = byte, 1 = half, 2 = word (3 is issued as word)
//   mem_addrM       byte address
//   mem_wdataM      lane-aligned store data
//   except_flushM   M-stage exception pending: blocks issue / kills in flight
//   other_stall     OR of the non-data stall sources
//   d_stall         data-side stall to the hazard unit
//   mem_rdataM      load result for the M stage
//   bus             data bus (master side)
// -----------------------------------------------------------------------------
module dmem_req_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_enM,
    input  logic                 mem_wenM,
    input  logic [1:0]           mem_sizeM,
    input  logic [AW-1:0]        mem_addrM,
    input  logic [DW-1:0]        mem_wdataM,
    input  logic                 except_flushM,
    input  logic                 other_stall,
    output logic                 d_stall,
    output logic [DW-1:0]        mem_rdataM,
    dmem_req_ctrl_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic          kill_reg, kill_next;
    logic [DW-1:0] rdata_reg, rdata_next;

    // Latched request payload, replayed on the bus while waiting for addr_ok.
    logic          wr_reg;
    logic [1:0]    size_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;

    logic          start;
    logic [1:0]    size_in;

    // The illegal size encoding is issued as a word access.
    assign size_in = (mem_sizeM == 2'd3) ? 2'd2 : mem_sizeM;
    assign start   = (state_reg == IDLE) && mem_enM && !except_flushM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            kill_reg  <= 1'b0;
            rdata_reg <= '0;
            wr_reg    <= 1'b0;
            size_reg  <= 2'd0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            kill_reg  <= kill_next;
            rdata_reg <= rdata_next;
            if (start) begin
                wr_reg    <= mem_wenM;
                size_reg  <= size_in;
                addr_reg  <= mem_addrM;
                wdata_reg <= mem_wdataM;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        kill_next      = kill_reg;
        rdata_next     = rdata_reg;
        bus.data_req   = 1'b0;
        bus.data_wr    = wr_reg;
        bus.data_size  = size_reg;
        bus.data_addr  = addr_reg;
        bus.data_wdata = wdata_reg;

        case (state_reg)
            IDLE: begin
                // Issue straight from the M inputs so a request costs no
                // extra cycle; the payload is captured for a possible ADDR wait.
                bus.data_req   = start;
                bus.data_wr    = mem_wenM;
                bus.data_size  = size_in;
                bus.data_addr  = mem_addrM;
                bus.data_wdata = mem_wdataM;
                if (start) begin
                    state_next = bus.data_addr_ok ? DATA : ADDR;
                end
            end
            ADDR: begin
                // A request once raised is never withdrawn, even if killed.
                bus.data_req = 1'b1;
                if (except_flushM) begin
                    kill_next = 1'b1;
                end
                if (bus.data_addr_ok) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (except_flushM) begin
                    kill_next = 1'b1;
                end
                if (bus.data_data_ok) begin
                    // Store completions carry no data; killed results are dropped.
                    if (!kill_reg && !wr_reg) begin
                        rdata_next = bus.data_rdata;
                    end
                    kill_next = 1'b0;
                    if (kill_reg) begin
                        state_next = IDLE;
                    end else if (other_stall) begin
                        state_next = HOLD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!other_stall) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A killed transaction keeps the stall up through its data_ok cycle so the
    // discarded result never reaches the pipeline.
    assign d_stall = start
                   || (state_reg == ADDR)
                   || ((state_reg == DATA) && (!bus.data_data_ok || kill_reg));

    assign mem_rdataM = (state_reg == DATA) ? bus.data_rdata : rdata_reg;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
module tb_dmem_req_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_en, mem_wen, except_flush, other_stall;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          d_stall;
    logic [DW-1:0] mem_rdata;
    logic          addr_ok, data_ok;
    logic [DW-1:0] rdata_drv;

    int            vectors = 0;
    int            miscompares = 0;
    logic [31:0]   rq;  // reference copy of the held load result

    always #5 clk = ~clk;

    dmem_req_ctrl_if #(.AW(AW), .DW(DW)) bus_if ();

    assign bus_if.data_addr_ok = addr_ok;
    assign bus_if.data_data_ok = data_ok;
    assign bus_if.data_rdata   = rdata_drv;

    dmem_req_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_enM      (mem_en),
        .mem_wenM     (mem_wen),
        .mem_sizeM    (mem_size),
        .mem_addrM    (mem_addr),
        .mem_wdataM   (mem_wdata),
        .except_flushM(except_flush),
        .other_stall  (other_stall),
        .d_stall      (d_stall),
        .mem_rdataM   (mem_rdata),
        .bus          (bus_if.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One cycle with nothing issued: either no memory op, or one blocked by
    // a pending exception.
    task automatic idle_cycle(input bit flushed_op);
        mem_en       = flushed_op;
        except_flush = flushed_op;
        mem_wen      = 1'($urandom);
        mem_size     = 2'($urandom);
        mem_addr     = $urandom;
        mem_wdata    = $urandom;
        other_stall  = 1'($urandom);
        addr_ok      = 1'b0;
        data_ok      = 1'b0;
        rdata_drv    = $urandom;
        @(negedge clk);
        chk("idle_req",   32'(bus_if.data_req), 32'd0);
        chk("idle_stall", 32'(d_stall), 32'd0);
        chk("idle_rdata", mem_rdata, rq);
        $display("idle  flushed=%0d rdata=%08h", flushed_op, mem_rdata);
        next_cycle();
    endtask

    // One whole transaction, issued at k=0. The slave accepts after a wait
    // cycles (k=a) and completes d cycles later (k=a+d). kj!=0 pulses the
    // exception at cycle kj. h>0 keeps other_stall high for h cycles past
    // data_ok.
    task automatic run_txn(input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdv,
                           input int a, input int d, input int kj, input int h);
        logic [1:0] size_exp;
        bit         killed;
        int         done_k, total;
        size_exp = (sz == 2'd3) ? 2'd2 : sz;
        killed   = (kj != 0);
        done_k   = a + d;
        total    = done_k + ((!killed && h > 0) ? h + 1 : 0);
        for (int k = 0; k <= total; k++) begin
            addr_ok   = (k == a);
            data_ok   = (k == done_k);
            rdata_drv = (k == done_k) ? rdv : $urandom;
            if (k > done_k) except_flush = 1'($urandom);
            else            except_flush = killed && (k == kj);
            if (k == done_k)     other_stall = killed ? 1'($urandom) : (h > 0);
            else if (k > done_k) other_stall = (k <= done_k + h);
            else                 other_stall = 1'($urandom);
            if (k == 0) begin
                mem_en = 1'b1; mem_wen = wr; mem_size = sz; mem_addr = addr; mem_wdata = wd;
            end else begin
                mem_en    = 1'($urandom);
                mem_wen   = 1'($urandom);
                mem_size  = 2'($urandom);
                mem_addr  = $urandom;
                mem_wdata = $urandom;
            end
            @(negedge clk);
            chk("req",   32'(bus_if.data_req), 32'(k <= a));
            chk("stall", 32'(d_stall), 32'((k < done_k) || (k == done_k && killed)));
            if (k <= a) begin
                chk("wr",    32'(bus_if.data_wr), 32'(wr));
                chk("size",  32'(bus_if.data_size), 32'(size_exp));
                chk("addr",  bus_if.data_addr, addr);
                chk("wdata", bus_if.data_wdata, wd);
            end
            if (k == done_k && !wr && !killed) chk("fwd_rdata", mem_rdata, rdv);
            if (k > done_k) chk("hold_rdata", mem_rdata, rq);
            if (k == done_k && !wr && !killed) rq = rdv;
            next_cycle();
        end
        $display("txn   wr=%0d size=%0d addr=%08h a=%0d d=%0d kill=%0d hold=%0d rq=%08h",
                 wr, sz, addr, a, d, kj, h, rq);
    endtask

    initial begin
        rst = 1'b1;
        mem_en = 1'b0; mem_wen = 1'b0; mem_size = 2'd0; mem_addr = '0; mem_wdata = '0;
        except_flush = 1'b0; other_stall = 1'b0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata_drv = '0;
        rq = 32'd0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        idle_cycle(1'b0);

        // Directed cases.
        run_txn(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 0);
        idle_cycle(1'b0);
        run_txn(1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB, 32'h0BAD_0BAD, 3, 1, 0, 0);
        run_txn(1'b0, 2'd2, 32'h8000_0020, 32'h0, 32'h1234_5678, 0, 1, 0, 3);
        idle_cycle(1'b1);
        run_txn(1'b0, 2'd2, 32'h8000_0024, 32'h0, 32'h55AA_55AA, 0, 3, 1, 0);
        idle_cycle(1'b0);
        run_txn(1'b1, 2'd1, 32'h8000_0042, 32'hBEEF_0000, 32'hFFFF_FFFF, 1, 2, 0, 2);
        idle_cycle(1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int a, d, kj, h, gap;
            a  = int'($urandom_range(0, 3));
            d  = int'($urandom_range(1, 3));
            h  = int'($urandom_range(0, 3));
            kj = 0;
            if (a + d >= 2 && $urandom_range(0, 3) == 0) kj = int'($urandom_range(1, a + d - 1));
            run_txn(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, a, d, kj, h);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle_cycle(1'($urandom));
        end

        // Reset while waiting for addr_ok abandons the request.
        mem_en = 1'b1; mem_wen = 1'b0; mem_size = 2'd2; mem_addr = 32'h8000_0100;
        except_flush = 1'b0; other_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
        @(negedge clk);
        chk("rst_issue_req", 32'(bus_if.data_req), 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_addr_req", 32'(bus_if.data_req), 32'd1);
        next_cycle();
        rst = 1'b0;
        rq  = 32'd0;
        mem_en = 1'b0;
        @(negedge clk);
        chk("rst_req",   32'(bus_if.data_req), 32'd0);
        chk("rst_stall", 32'(d_stall), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        $display("reset during ADDR rdata=%08h", mem_rdata);
        next_cycle();
        run_txn(1'b0, 2'd2, 32'h8000_0200, 32'h0, 32'hCAFE_F00D, 0, 1, 0, 1);
        idle_cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
